mem_port_arbiter: RTL and testbench

- Shares one byte-addressed, single-port program/data memory between the instruction-fetch requester and the load/store requester of the rv32i core.
- Arbitrates between the two requesters, latches the winning request, and drives a registered memory command.
- Counts the memory read latency, then returns a one-cycle response pulse to the requester that was granted.
- Allows one outstanding transaction at a time.

---
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin fetch/data arbiter for a single-port memory, one outstanding access.
// Define MEM_ARB_DATA_PRIO_EN to make data win every tie (fixed priority).
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_req_addr,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rsp_data,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [AW-1:0]   d_req_addr,
  input  logic            d_req_we,
  input  logic [DW/8-1:0] d_req_be,
  input  logic [DW-1:0]   d_req_wdata,
  output logic            d_rsp_valid,
  output logic [DW-1:0]   d_rsp_data,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t     r_state;
  logic       r_last_d;
  logic       r_gnt_d;
  logic [3:0] r_cnt;
  logic       w_idle;
  logic       w_gnt_d;
`ifdef MEM_ARB_DATA_PRIO_EN
  assign w_gnt_d = d_req_valid;
`else
  assign w_gnt_d = d_req_valid & (~if_req_valid | ~r_last_d);
`endif
  assign w_idle       = (r_state == IDLE) & ~rst;
  assign d_req_ready  = w_idle & w_gnt_d;
  assign if_req_ready = w_idle & if_req_valid & ~w_gnt_d;
  // mem_* registers double as the latched command; they hold while mem_en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_d     <= 1'b1;
      r_gnt_d      <= 1'b0;
      r_cnt        <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_data   <= '0;
    end else begin
      mem_en       <= 1'b0;
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      case (r_state)
        IDLE: if (if_req_ready | d_req_ready) begin
          r_gnt_d  <= d_req_ready;
          r_last_d <= d_req_ready;
          mem_en   <= 1'b1;
          mem_we   <= d_req_ready & d_req_we;
          mem_be   <= d_req_ready ? d_req_be : '1;
          mem_addr <= d_req_ready ? d_req_addr : {if_req_addr[AW-1:2], 2'b00};
          if (d_req_ready) mem_wdata <= d_req_wdata;
          r_state  <= ISSUE;
        end
        ISSUE: begin
          r_cnt   <= 4'(MEM_LAT);
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= IDLE;
            if (r_gnt_d) begin
              d_rsp_valid <= 1'b1;
              d_rsp_data  <= mem_we ? '0 : mem_rdata;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= mem_rdata;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two lanes (MEM_LAT 1 and 3), each a DUT against a timestamp-based transaction model.
module tb_mem_port_arbiter;
  typedef struct packed {
    logic        d;
    logic [31:0] a;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int passed = 0;
  task automatic chk(input int lane, input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL L%0d %s: got %h expected %h", lane, tag, act, exp);
  endtask
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g ? 3 : 1;
    logic        rst = 1'b1;
    logic        ifv = 1'b0, dv = 1'b0, dwe = 1'b0;
    logic [31:0] ifa = '0, da = '0, dwd = '0, rdata = '0;
    logic [3:0]  dbe = '0;
    logic        ifr, ifrv, dr, drv, men, mwe;
    logic [31:0] ifrd, drd, maddr, mwd;
    logic [3:0]  mbe;
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(ifv), .if_req_ready(ifr), .if_req_addr(ifa),
      .if_rsp_valid(ifrv), .if_rsp_data(ifrd),
      .d_req_valid(dv), .d_req_ready(dr), .d_req_addr(da), .d_req_we(dwe),
      .d_req_be(dbe), .d_req_wdata(dwd), .d_rsp_valid(drv), .d_rsp_data(drd),
      .mem_en(men), .mem_we(mwe), .mem_be(mbe), .mem_addr(maddr),
      .mem_wdata(mwd), .mem_rdata(rdata)
    );
    int          cyc = 0, free_at = 0, t0 = 0, mode = 0;
    bit          last_d = 1'b1, pend = 1'b0, if_acc = 1'b0, d_acc = 1'b0, fin = 1'b0;
    req_t        cur;
    req_t        dq[$];
    logic [31:0] word = '0, e_ifd = '0, e_dd = '0, m_addr = '0, m_wd = '0;
    logic        m_we = 1'b0;
    logic [3:0]  m_be = '0;
    // memory returns the expected word only in the cycle it is due, noise otherwise
    always @(posedge clk) begin
      req_t r;
      cyc++;
      #1;
      rdata = (pend && cyc == t0 + 1 + LAT) ? word : $urandom;
      if (if_acc) begin ifv = 1'b0; ifa = $urandom; end
      if (d_acc) begin dv = 1'b0; da = $urandom; dwd = $urandom; dbe = 4'($urandom); dwe = 1'($urandom); end
      if (mode == 1) begin
        if (!ifv && $urandom_range(2) == 0) begin ifv = 1'b1; ifa = $urandom; end
        if (!dv && $urandom_range(2) == 0) begin
          dv = 1'b1; da = $urandom; dwe = 1'($urandom); dbe = 4'($urandom); dwd = $urandom;
        end
      end else if (mode == 2) begin
        if (!ifv) begin ifv = 1'b1; ifa = 32'h0; end
        if (!dv) begin dv = 1'b1; da = 32'h200; dwe = 1'b0; dbe = 4'hf; end
      end else if (mode == 3 && !ifv && !dv && dq.size() > 0) begin
        r = dq.pop_front();
        if (r.d) begin dv = 1'b1; da = r.a; dwe = r.we; dbe = r.be; dwd = r.wd; end
        else begin ifv = 1'b1; ifa = r.a; end
      end
    end
    always @(negedge clk) begin
      bit gi, gd, e_ir, e_dr;
      gi = 1'b0;
      gd = 1'b0;
      if (!rst && cyc >= free_at) begin
`ifdef MEM_ARB_DATA_PRIO_EN
        gd = dv;
`else
        gd = dv && (!ifv || !last_d);
`endif
        gi = ifv && !gd;
      end
      chk(g, "if_req_ready", ifr, gi);
      chk(g, "d_req_ready", dr, gd);
      if_acc = ifv && ifr;
      d_acc  = dv && dr;
      chk(g, "mem_en", men, pend && cyc == t0 + 1);
      chk(g, "mem_addr", maddr, m_addr);
      chk(g, "mem_we", mwe, m_we);
      chk(g, "mem_be", mbe, m_be);
      chk(g, "mem_wdata", mwd, m_wd);
      e_ir = pend && !cur.d && cyc == t0 + 2 + LAT;
      e_dr = pend && cur.d && cyc == t0 + 2 + LAT;
      if (e_ir) e_ifd = word;
      if (e_dr) e_dd = cur.we ? 32'h0 : word;
      chk(g, "if_rsp_valid", ifrv, e_ir);
      chk(g, "d_rsp_valid", drv, e_dr);
      chk(g, "if_rsp_data", ifrd, e_ifd);
      chk(g, "d_rsp_data", drd, e_dd);
      if (e_ir || e_dr) pend = 1'b0;
      if (rst) begin
        pend = 1'b0; free_at = 0; last_d = 1'b1; e_ifd = '0; e_dd = '0;
        m_addr = '0; m_we = 1'b0; m_be = '0; m_wd = '0;
      end else if (gi || gd) begin
        cur = gd ? req_t'{1'b1, da, dwe, dbe, dwd} : req_t'{1'b0, {ifa[31:2], 2'b00}, 1'b0, 4'hf, m_wd};
        pend = 1'b1; t0 = cyc; free_at = cyc + LAT + 2; last_d = gd; word = $urandom;
        m_addr = cur.a; m_we = cur.we; m_be = cur.be; m_wd = cur.wd;
      end
    end
    task automatic wait_idle();
      int i;
      for (i = 0; i < 300 && (dq.size() > 0 || ifv || dv || pend); i++) @(posedge clk);
      chk(g, "idle_timeout", i, i < 300 ? i : -1);
    endtask
    initial begin
      int i;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      dq.push_back(req_t'{1'b0, 32'h10, 1'b0, 4'h0, 32'h0});
      dq.push_back(req_t'{1'b1, 32'h104, 1'b1, 4'b0011, 32'hDEADBEEF});
      dq.push_back(req_t'{1'b0, 32'h13, 1'b0, 4'h0, 32'h0});
      dq.push_back(req_t'{1'b1, 32'h40, 1'b0, 4'hf, 32'h0});
      mode = 3;
      wait_idle();
      mode = 2;
      repeat (30) @(posedge clk);
      mode = 0;
      wait_idle();
      dq.push_back(req_t'{1'b0, 32'h20, 1'b0, 4'h0, 32'h0});
      mode = 3;
      for (i = 0; i < 100; i++) begin
        @(posedge clk);
        #2;
        if (pend && cyc == t0 + 2) break;
      end
      chk(g, "reach_wait", i < 100, 1'b1);
      rst = 1'b1;
      mode = 2;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (12) @(posedge clk);
      mode = 0;
      wait_idle();
      mode = 1;
      repeat (400) @(posedge clk);
      mode = 0;
      wait_idle();
      fin = 1'b1;
    end
  end
  initial begin
    int i;
    for (i = 0; i < 20000 && !(lane[0].fin && lane[1].fin); i++) @(posedge clk);
    chk(0, "finished", lane[0].fin && lane[1].fin, 1'b1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
